// File: rtl/keypad_pkg.sv
// Shared types, key map and helpers for the 4x4 keypad scan controller.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  // Result of decoding a 4-bit vector that is expected to be one-hot.
  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } oh_t;

  // Hex code per [row][column]; '*' maps to E and '#' maps to F.
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Index of the single set bit; valid is low for zero or multiple bits.
  function automatic oh_t onehot_idx(input logic [3:0] v);
    oh_t res;
    res.valid = 1'b1;
    res.idx   = 2'd0;
    case (v)
      4'b0001: res.idx = 2'd0;
      4'b0010: res.idx = 2'd1;
      4'b0100: res.idx = 2'd2;
      4'b1000: res.idx = 2'd3;
      default: res.valid = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_col_sync.sv
// Two-flop synchronizer for the raw active-low keypad columns.
module col_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] col_s
);

  logic [3:0] meta;

  // Idle (all released) is all-ones, so that is the reset value of both stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta  <= 4'b1111;
      col_s <= 4'b1111;
    end else begin
      meta  <= col_n;
      col_s <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Row-scan sequencer with press/release debounce; one event per physical press.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned DWELL           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] rows,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic [1:0] state
);

  localparam int unsigned DW = $clog2(DWELL);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [CW-1:0] DEB_MAX    = CW'(DEBOUNCE_CYCLES);

  scan_state_t   cur_state, nxt_state;
  logic [3:0]    col_s;
  logic [3:0]    act;
  logic [1:0]    row_idx, row_idx_nxt;
  logic [1:0]    c_idx, c_idx_nxt;
  logic [DW-1:0] dwell, dwell_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [3:0]    rows_nxt;
  logic          valid_nxt;
  logic [3:0]    code_nxt;
  logic          held_nxt;
  logic [3:0]    col_mask;
  oh_t           sel;

  col_sync u_col_sync (
    .clk   (clk),
    .reset (reset),
    .col_n (col_n),
    .col_s (col_s)
  );

  assign act   = ~col_s;
  assign state = cur_state;

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= SCAN;
      rows      <= 4'b0001;
      row_idx   <= 2'd0;
      c_idx     <= 2'd0;
      dwell     <= '0;
      cnt       <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      key_held  <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      rows      <= rows_nxt;
      row_idx   <= row_idx_nxt;
      c_idx     <= c_idx_nxt;
      dwell     <= dwell_nxt;
      cnt       <= cnt_nxt;
      key_valid <= valid_nxt;
      key_code  <= code_nxt;
      key_held  <= held_nxt;
    end
  end

  // Next-state and next-output decode; rows stay frozen outside SCAN.
  always_comb begin
    nxt_state   = cur_state;
    rows_nxt    = rows;
    row_idx_nxt = row_idx;
    c_idx_nxt   = c_idx;
    dwell_nxt   = dwell;
    cnt_nxt     = cnt;
    valid_nxt   = 1'b0;
    code_nxt    = key_code;
    held_nxt    = key_held;
    sel         = onehot_idx(act);
    col_mask    = 4'b0001 << c_idx;
    cnt_inc     = (cnt == DEB_MAX) ? cnt : cnt + CW'(1);

    case (cur_state)
      SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_nxt = '0;
          if (sel.valid) begin
            c_idx_nxt = sel.idx;
            cnt_nxt   = '0;
            nxt_state = DEBOUNCE;
          end else begin
            rows_nxt    = {rows[2:0], rows[3]};
            row_idx_nxt = row_idx + 2'd1;
          end
        end else begin
          dwell_nxt = dwell + DW'(1);
        end
      end

      DEBOUNCE: begin
        if (act == col_mask) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == DEB_MAX) begin
            valid_nxt = 1'b1;
            code_nxt  = KEYMAP[row_idx][c_idx];
            held_nxt  = 1'b1;
            cnt_nxt   = '0;
            nxt_state = HELD;
          end
        end else begin
          rows_nxt    = {rows[2:0], rows[3]};
          row_idx_nxt = row_idx + 2'd1;
          dwell_nxt   = '0;
          cnt_nxt     = '0;
          nxt_state   = SCAN;
        end
      end

      HELD: begin
        if (!act[c_idx]) begin
          cnt_nxt   = '0;
          nxt_state = RELEASE;
        end
      end

      RELEASE: begin
        if (act == 4'b0000) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == DEB_MAX) begin
            held_nxt    = 1'b0;
            rows_nxt    = {rows[2:0], rows[3]};
            row_idx_nxt = row_idx + 2'd1;
            dwell_nxt   = '0;
            cnt_nxt     = '0;
            nxt_state   = SCAN;
          end
        end else begin
          cnt_nxt = '0;
        end
      end

      default: nxt_state = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench: keypad matrix model driving col_n from rows, plus event scoreboard.
module tb_keypad_scan_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] col_n;
  logic [3:0] rows;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic [1:0] state;

  logic [3:0] pressed [4];
  logic [3:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  keypad_scan_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .col_n     (col_n),
    .rows      (rows),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix model: a pressed key pulls its column low only while its row is driven.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      if (rows[r] === 1'b1) col_n = col_n & ~pressed[r];
  end

  // Scoreboard: every key_valid pulse must match the oldest expected code.
  always @(negedge clk) begin
    logic [3:0] e;
    if (reset === 1'b1 && key_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event code=%h none expected", key_code);
      end else begin
        e = exp_q.pop_front();
        if (key_code !== e) begin
          errors++;
          $display("FAIL event_code got=%h exp=%h", key_code, e);
        end
      end
    end
  end

  task automatic release_all();
    for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;
  endtask

  // Returns at the first negedge after rows switches to target.
  task automatic wait_row_fresh(input logic [3:0] target, output bit ok);
    int n = 0;
    while (rows === target && n < 40) begin @(negedge clk); n++; end
    do begin @(negedge clk); n++; end while (rows !== target && n < 80);
    ok = (rows === target);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_scan(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (state === 2'd0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [3:0] one;
    logic [3:0] exp_rows;
    reset = 1'b0;
    for (int r = 0; r < 4; r++) pressed[r] = 4'b1111;
    repeat (3) @(negedge clk);
    checks++; if (col_n !== 4'b0000) begin errors++; $display("FAIL rst_col_n got=%b exp=0000", col_n); end
    checks++; if (rows !== 4'b0001) begin errors++; $display("FAIL rst_rows got=%b exp=0001", rows); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rst_held got=%b exp=0", key_held); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", key_valid); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL rst_code got=%h exp=0", key_code); end
    release_all();
    @(negedge clk);
    reset = 1'b1;
    one = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_rows = one << ((k / 3) % 4);
      checks++;
      if (rows !== exp_rows) begin errors++; $display("FAIL scan_rows k=%0d got=%b exp=%b", k, rows, exp_rows); end
    end
  endtask

  task automatic test_press();
    bit ok;
    wait_row_fresh(4'b0010, ok);
    checks++; if (!ok) begin errors++; $display("FAIL press_wait_row got=%b exp=0010", rows); end
    pressed[1] = 4'b0010;
    exp_q.push_back(4'h5);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (key_valid !== (k == 7)) begin errors++; $display("FAIL press_valid k=%0d got=%b exp=%b", k, key_valid, (k == 7)); end
      checks++;
      if (rows !== 4'b0010) begin errors++; $display("FAIL press_rows k=%0d got=%b exp=0010", k, rows); end
      if (k >= 3 && k <= 6) begin
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL press_debounce k=%0d got=%0d exp=1", k, state); end
      end
      if (k >= 7) begin
        checks++;
        if (state !== 2'd2 || key_held !== 1'b1 || key_code !== 4'h5) begin
          errors++;
          $display("FAIL press_held k=%0d got state=%0d held=%b code=%h exp 2/1/5", k, state, key_held, key_code);
        end
      end
    end
  endtask

  task automatic test_release();
    pressed[1] = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (key_valid !== 1'b0) begin errors++; $display("FAIL rel_valid k=%0d got=%b exp=0", k, key_valid); end
      checks++;
      if (key_held !== (k <= 6)) begin errors++; $display("FAIL rel_held k=%0d got=%b exp=%b", k, key_held, (k <= 6)); end
      if (k >= 3 && k <= 6) begin
        checks++;
        if (state !== 2'd3) begin errors++; $display("FAIL rel_state k=%0d got=%0d exp=3", k, state); end
      end
      if (k == 7) begin
        checks++;
        if (rows !== 4'b0100 || state !== 2'd0) begin
          errors++;
          $display("FAIL rel_resume got rows=%b state=%0d exp 0100/0", rows, state);
        end
      end
    end
  endtask

  task automatic test_bounce();
    bit ok;
    for (int g = 0; g < 3; g++) begin
      wait_row_fresh(4'b1000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bounce_wait_row got=%b exp=1000", rows); end
      pressed[3] = 4'b0100;
      repeat (2) @(negedge clk);
      pressed[3] = 4'b0000;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        checks++;
        if (key_valid !== 1'b0 || state === 2'd2) begin
          errors++;
          $display("FAIL bounce_event g=%0d got valid=%b state=%0d exp 0/not2", g, key_valid, state);
        end
      end
    end
    wait_row_fresh(4'b1000, ok);
    pressed[3] = 4'b0100;
    exp_q.push_back(4'hF);
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bounce_final got=no_event exp=event"); end
    @(negedge clk);
    checks++; if (key_code !== 4'hF || state !== 2'd2) begin errors++; $display("FAIL bounce_code got=%h/%0d exp=F/2", key_code, state); end
    release_all();
    wait_scan(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bounce_rescan got=%0d exp=0", state); end
  endtask

  task automatic test_multi_key();
    bit ok;
    wait_row_fresh(4'b0001, ok);
    pressed[0] = 4'b0011;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++;
      if (state !== 2'd0 || key_valid !== 1'b0) begin
        errors++;
        $display("FAIL multi_reject k=%0d got state=%0d valid=%b exp 0/0", k, state, key_valid);
      end
      if (k == 3) begin
        checks++;
        if (rows !== 4'b0010) begin errors++; $display("FAIL multi_rotate got=%b exp=0010", rows); end
      end
    end
    pressed[0] = 4'b1000;
    exp_q.push_back(4'hA);
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL multi_a_press got=no_event exp=event"); end
    pressed[0] = 4'b1001;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (key_valid !== 1'b0 || state !== 2'd2 || key_code !== 4'hA) begin
        errors++;
        $display("FAIL multi_held k=%0d got valid=%b state=%0d code=%h exp 0/2/A", k, key_valid, state, key_code);
      end
    end
    release_all();
    wait_scan(ok);
    checks++; if (!ok) begin errors++; $display("FAIL multi_rescan got=%0d exp=0", state); end
  endtask

  task automatic test_two_rows();
    bit ok;
    wait_row_fresh(4'b0001, ok);
    pressed[1] = 4'b0001;
    pressed[2] = 4'b0001;
    exp_q.push_back(4'h4);
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL two_rows_event got=no_event exp=event"); end
    checks++; if (rows !== 4'b0010) begin errors++; $display("FAIL two_rows_frozen got=%b exp=0010", rows); end
    release_all();
    wait_scan(ok);
    checks++; if (!ok) begin errors++; $display("FAIL two_rows_rescan got=%0d exp=0", state); end
  endtask

  task automatic test_async_reset();
    bit ok;
    pressed[2] = 4'b0100;
    exp_q.push_back(4'h9);
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ares_first got=no_event exp=event"); end
    @(negedge clk);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL ares_held got=%0d exp=2", state); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (rows !== 4'b0001 || state !== 2'd0 || key_held !== 1'b0 || key_valid !== 1'b0 || key_code !== 4'h0) begin
      errors++;
      $display("FAIL ares_values got rows=%b state=%0d held=%b valid=%b code=%h exp 0001/0/0/0/0",
               rows, state, key_held, key_valid, key_code);
    end
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(4'h9);
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ares_redetect got=no_event exp=event"); end
    release_all();
    wait_scan(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ares_rescan got=%0d exp=0", state); end
  endtask

  initial begin
    reset = 1'b0;
    release_all();
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_multi_key();
    test_two_rows();
    test_async_reset();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL missing_events got=%0d pending exp=0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequences the 4x4 matrix keypad. It drives the one-hot row scan, synchronizes the column returns and debounces press and release.
- Emits exactly one key event per physical press: a single-cycle pulse plus a 4-bit hex code.
- Sits between the keypad pins and the display/hold-state logic, on the divided scan clock.
- Replaces the free-running row cycler, separate synchronizer and press decoder with one controlled sequencer.

Parameters:
- DWELL, 3: clk cycles spent on each row before sampling. Minimum 3: one cycle to drive, two to synchronize.
- DEBOUNCE_CYCLES, 4: consecutive stable samples required to accept a press or a release. Range 1..15.

Ports:
- clk  input  1  scan clock (divided oscillator).
- reset  input  1  asynchronous, active-low reset.
- col_n  input  4  raw keypad columns, active-low (pulled up), asynchronous to clk.
- rows  output  4  one-hot active-high row drive; the top level inverts it to the pins.
- key_valid  output  1  one-cycle pulse when a debounced press is accepted.
- key_code  output  4  hex code of the last accepted key; holds until the next accepted key.
- key_held  output  1  high while the accepted key remains pressed, including the release-debounce phase.
- state  output  2  current FSM state, for debug LEDs.

Behaviour:
- Reset (asynchronous, reset=0):
  - rows=4'b0001, key_valid=0, key_code=4'h0, key_held=0, state=SCAN.
  - Dwell and debounce counters = 0.
  - Synchronizer flops = 4'b1111 (idle).
- Synchronizer: col_n passes through two flops to give col_s. The active vector is act = ~col_s.
- SCAN (2'd0):
  - The dwell counter counts 0..DWELL-1 with rows held constant.
  - At dwell = DWELL-1, act is sampled.
  - If act has exactly one bit set: latch row index r and column index c, clear the debounce counter, go to DEBOUNCE, keep rows frozen.
  - If act is zero or has more than one bit set: rotate rows left (0001->0010->0100->1000->0001) and clear dwell.
- DEBOUNCE (2'd1):
  - Each cycle, compare act against one-hot(c).
  - On a match, increment the counter. When the count reaches DEBOUNCE_CYCLES:
    - assert key_valid for exactly one cycle;
    - load key_code = KEYMAP[r][c] in the same cycle;
    - go to HELD.
  - On a mismatch: abort with no event, rotate to the next row, dwell=0, go to SCAN.
- HELD (2'd2):
  - key_held=1 and rows stay frozen.
  - Remain here while act[c]=1. Other columns in the same row are ignored, so no second event is produced.
  - When act[c]=0, clear the counter and go to RELEASE.
- RELEASE (2'd3):
  - key_held stays 1.
  - Increment the counter on act==0. Any active bit resets the counter to 0 without generating an event.
  - When the count reaches DEBOUNCE_CYCLES: key_held=0, rotate to the next row, dwell=0, go to SCAN.
- Latency: from the first SCAN sample seeing the key to the key_valid pulse is DEBOUNCE_CYCLES cycles.
- KEYMAP (rows 0..3, columns 0..3):
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: E 0 F D (* -> E, # -> F)
- Boundary conditions:
  - Two keys in the same row are rejected in SCAN.
  - Two keys in different rows: the first row scanned wins.
  - A glitch shorter than DEBOUNCE_CYCLES produces no event.
  - Reset mid-operation returns to the reset values immediately; a key held through reset is re-detected as a new press after reset is released.
  - key_code is never modified outside an accepted press.
  - Counter widths are sized by $clog2. Counters saturate and never wrap.

Decomposition:
- Package keypad_pkg:
  - state enum scan_state_t {SCAN, DEBOUNCE, HELD, RELEASE} (2-bit).
  - Constant KEYMAP as a 4x4 array of 4-bit values.
  - Function onehot_idx (4-bit one-hot to 2-bit index, plus a valid flag).
- Sub-module col_sync: 4-bit two-flop synchronizer with reset value 4'b1111.
- The FSM, dwell counter and debounce counter live in keypad_scan_ctrl.

Test Plan:
- Reset: hold reset=0 with col_n=4'b0000. Expect rows=0001, key_held=0, key_valid=0, key_code=0, state=0. Release reset with col_n=1111: rows advances every 3 cycles, 0001->0010->0100->1000->0001.
- Single press "5" (row1, col1): drive col_n=1101 whenever rows=0010 and hold it. Expect exactly one key_valid pulse 4 cycles after the sampling edge, key_code=4'h5, then key_held=1 with rows frozen at 0010 while pressed.
- Release: from the previous case, set col_n=1111. Expect key_held=1 for 4 cycles, then 0. SCAN resumes at rows=0100. No additional key_valid pulse occurs.
- Bounce: press "#" (row3, col2) for 2 cycles, release, then repeat 3 times. Expect no key_valid pulse. A final stable press gives one pulse with key_code=4'hF.
- Multi-key rejection: in row0, assert col_n=1100 (keys 1 and 2). Expect no event and continued scanning. A second column pressed while "A" is HELD produces no event, and key_code stays 4'hA.
- Async reset mid-HELD: assert reset=0 asynchronously. Outputs return to reset values without waiting for a clock edge. With the key still down after release, a new key_valid pulse occurs after scan plus debounce.
